// File: rtl/bus_slave_mem.sv
// Slave-side responder for one crossbar slave port: word-addressed memory with
// programmable wait states, registered read data and saturating access counters.
module bus_slave_mem #(
    parameter int N  = 32,
    parameter int AW = 6,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [N-1:0]  addr,
    input  logic          cmd,
    input  logic [N-1:0]  wdata,
    output logic          ack,
    output logic [N-1:0]  rdata,
    input  logic [3:0]    wait_cfg,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt
);

    localparam int DEPTH = 2 ** AW;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic          state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] idx;
    logic          ack_raw;
    logic          wr_done;
    logic          rd_done;

    // Bits above the index are the crossbar slave select and alias to the same word.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[N-1:AW];

    assign idx = addr[AW-1:0];

    always_comb begin
        if (state_q == ST_IDLE) begin
            ack_raw = req && (wait_cfg == 4'd0);
        end else begin
            ack_raw = req && (cnt_q == 4'd0);
        end
    end

    // Reset must also mask ack: in IDLE with wait_cfg==0 the raw term could be high.
    assign ack     = reset && ack_raw;
    assign wr_done = ack && cmd;
    assign rd_done = ack && !cmd;

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req && (wait_cfg != 4'd0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_cfg - 4'd1;
                end
            end
            default: begin
                if (!req || (cnt_q == 4'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (rd_done) begin
            rdata_d = mem[idx];
            if (rd_cnt_q != {CW{1'b1}}) rd_cnt_d = rd_cnt_q + CW'(1);
        end
        if (wr_done && (wr_cnt_q != {CW{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // NOTE: the memory array has no reset so it can map onto RAM macros; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_done) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata  = rdata_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule
